vc_input_port: RTL and testbench

VC_INPUT_PORT -- requirements
Module: vc_input_port

---
 rtl/noc_params.sv | 46 ++++
 rtl/rc_unit.sv | 24 ++
 rtl/vc_buffer.sv | 116 +++++++++++
 rtl/vc_input_port.sv | 104 ++++++++++
 tb/tb_vc_input_port.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_params.sv
// Shared NoC types and constants: flit format, output ports, VC state.
// A head flit carries its destination in data: x in the low bits, y just above.
package noc_params;

  localparam int VC_NUM           = 2;
  localparam int VC_SIZE          = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int DEST_ADDR_SIZE_X = 4;
  localparam int DEST_ADDR_SIZE_Y = 4;
  localparam int FLIT_DATA_SIZE   = 16;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    SOUTH = 3'd2,
    WEST  = 3'd3,
    EAST  = 3'd4
  } port_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VA     = 2'd1,
    ACTIVE = 2'd2
  } vc_state_t;

  typedef struct packed {
    flit_label_t               flit_label;
    logic [VC_SIZE-1:0]        vc_id;
    logic [FLIT_DATA_SIZE-1:0] data;
  } flit_t;

  function automatic logic is_head(flit_label_t l);
    return (l == HEAD) || (l == HEADTAIL);
  endfunction

  function automatic logic is_tail(flit_label_t l);
    return (l == TAIL) || (l == HEADTAIL);
  endfunction

endpackage

// File: rtl/rc_unit.sv
// Dimension-ordered (X then Y) route computation; enable_skip forces delivery to LOCAL.
module rc_unit
  import noc_params::*;
(
  input  logic [DEST_ADDR_SIZE_X-1:0] x_current,
  input  logic [DEST_ADDR_SIZE_Y-1:0] y_current,
  input  logic [DEST_ADDR_SIZE_X-1:0] x_dest,
  input  logic [DEST_ADDR_SIZE_Y-1:0] y_dest,
  input  logic                        enable_skip,
  output port_t                       out_port
);

  always_comb begin
    out_port = LOCAL;
    if (!enable_skip) begin
      if (x_dest > x_current)      out_port = EAST;
      else if (x_dest < x_current) out_port = WEST;
      else if (y_dest > y_current) out_port = SOUTH;
      else if (y_dest < y_current) out_port = NORTH;
      else                         out_port = LOCAL;
    end
  end

endmodule

// File: rtl/vc_buffer.sv
// One virtual channel: flit FIFO with stored routes plus the IDLE/VA/ACTIVE packet FSM.
module vc_buffer
  import noc_params::*;
#(
  parameter int BUFFER_SIZE = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  flit_t              data_i,
  input  port_t              route_i,
  input  logic               write_i,
  input  logic               pop_i,
  input  logic               va_valid_i,
  input  logic [VC_SIZE-1:0] va_new_vc_i,
  output flit_t              front_o,
  output logic [VC_SIZE-1:0] downstream_vc_o,
  output port_t              out_port_o,
  output logic               va_request_o,
  output logic               sa_request_o,
  output logic               is_full_o,
  output logic               is_empty_o,
  output logic               error_o
);

  localparam int PTR_W = $clog2(BUFFER_SIZE);
  localparam int CNT_W = PTR_W + 1;

  flit_t              mem [BUFFER_SIZE];
  port_t              route_mem [BUFFER_SIZE];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  vc_state_t          state_reg, state_next;
  port_t              out_port_reg, out_port_next;
  logic [VC_SIZE-1:0] down_vc_reg, down_vc_next;
  logic               bad_reported_reg;
  logic               do_write, do_pop, idle_bad;

  assign is_empty_o = (count_reg == '0);
  assign is_full_o  = (count_reg == CNT_W'(BUFFER_SIZE));
  assign do_pop     = pop_i && !is_empty_o && (state_reg == ACTIVE);
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a write alongside it.
  assign do_write   = write_i && (!is_full_o || do_pop);
  assign front_o    = mem[rd_ptr_reg];
  assign idle_bad   = (state_reg == IDLE) && !is_empty_o && !is_head(front_o.flit_label);

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr_reg]       <= data_i;
      route_mem[wr_ptr_reg] <= route_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_write) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)   rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_write, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      out_port_reg     <= LOCAL;
      down_vc_reg      <= '0;
      bad_reported_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      out_port_reg     <= out_port_next;
      down_vc_reg      <= down_vc_next;
      bad_reported_reg <= bad_reported_reg | idle_bad;
    end
  end

  always_comb begin
    state_next    = state_reg;
    out_port_next = out_port_reg;
    down_vc_next  = down_vc_reg;
    case (state_reg)
      IDLE: begin
        if (!is_empty_o && is_head(front_o.flit_label)) begin
          state_next    = VA;
          out_port_next = route_mem[rd_ptr_reg];
        end
      end
      VA: begin
        if (va_valid_i) begin
          state_next   = ACTIVE;
          down_vc_next = va_new_vc_i;
        end
      end
      ACTIVE: begin
        if (do_pop && is_tail(front_o.flit_label)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A stranded non-head front can only be cleared by reset, so it is reported once.
  always_comb begin
    va_request_o    = (state_reg == VA);
    sa_request_o    = (state_reg == ACTIVE) && !is_empty_o;
    out_port_o      = out_port_reg;
    downstream_vc_o = down_vc_reg;
    error_o         = (write_i && is_full_o && !do_pop) || (idle_bad && !bad_reported_reg);
  end

endmodule

// File: rtl/vc_input_port.sv
// Router input port: routes arriving heads, buffers per VC and forwards SA winners to the crossbar.
module vc_input_port
  import noc_params::*;
#(
  parameter int VC_NUM      = noc_params::VC_NUM,
  parameter int BUFFER_SIZE = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DEST_ADDR_SIZE_X-1:0]      x_current,
  input  logic [DEST_ADDR_SIZE_Y-1:0]      y_current,
  input  flit_t                            data_i,
  input  logic                             valid_flit_i,
  input  logic [VC_NUM-1:0]                va_valid_i,
  input  logic [VC_NUM-1:0][VC_SIZE-1:0]   va_new_vc_i,
  input  logic                             sa_valid_i,
  input  logic [VC_SIZE-1:0]               sa_sel_vc_i,
  output flit_t                            xb_flit_o,
  output logic                             xb_valid_o,
  output logic [VC_NUM-1:0]                va_request_o,
  output logic [VC_NUM-1:0]                sa_request_o,
  output port_t [VC_NUM-1:0]               out_port_o,
  output logic [VC_NUM-1:0]                is_full_o,
  output logic [VC_NUM-1:0]                is_empty_o,
  output logic                             error_o
);

  port_t              route;
  flit_t              front [VC_NUM];
  logic [VC_SIZE-1:0] down_vc [VC_NUM];
  logic [VC_NUM-1:0]  write_vc, pop_vc, buf_error;
  logic               grant_ok;
  flit_t              sel_flit;
  flit_t              xb_flit_reg;
  logic               xb_valid_reg, error_reg;

  rc_unit u_rc (
    .x_current   (x_current),
    .y_current   (y_current),
    .x_dest      (data_i.data[DEST_ADDR_SIZE_X-1:0]),
    .y_dest      (data_i.data[DEST_ADDR_SIZE_X +: DEST_ADDR_SIZE_Y]),
    .enable_skip (1'b0),
    .out_port    (route)
  );

  genvar gi;
  generate
    for (gi = 0; gi < VC_NUM; gi++) begin : g_vc
      assign write_vc[gi] = valid_flit_i && (data_i.vc_id == VC_SIZE'(gi));
      assign pop_vc[gi]   = sa_valid_i && (sa_sel_vc_i == VC_SIZE'(gi)) && sa_request_o[gi];

      vc_buffer #(
        .BUFFER_SIZE (BUFFER_SIZE)
      ) u_buf (
        .clk             (clk),
        .rst             (rst),
        .data_i          (data_i),
        .route_i         (route),
        .write_i         (write_vc[gi]),
        .pop_i           (pop_vc[gi]),
        .va_valid_i      (va_valid_i[gi]),
        .va_new_vc_i     (va_new_vc_i[gi]),
        .front_o         (front[gi]),
        .downstream_vc_o (down_vc[gi]),
        .out_port_o      (out_port_o[gi]),
        .va_request_o    (va_request_o[gi]),
        .sa_request_o    (sa_request_o[gi]),
        .is_full_o       (is_full_o[gi]),
        .is_empty_o      (is_empty_o[gi]),
        .error_o         (buf_error[gi])
      );
    end
  endgenerate

  assign grant_ok = |pop_vc;

  // The winning front leaves carrying the downstream VC it was allocated.
  always_comb begin
    sel_flit = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      if (pop_vc[v]) begin
        sel_flit       = front[v];
        sel_flit.vc_id = down_vc[v];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xb_flit_reg  <= '0;
      xb_valid_reg <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      xb_valid_reg <= grant_ok;
      if (grant_ok) xb_flit_reg <= sel_flit;
      error_reg    <= (|buf_error) || (sa_valid_i && !grant_ok);
    end
  end

  assign xb_flit_o  = xb_flit_reg;
  assign xb_valid_o = xb_valid_reg;
  assign error_o    = error_reg;

endmodule

// File: tb/tb_vc_input_port.sv
// Directed bench for vc_input_port: VA/SA flow, full FIFO, interleaving, protocol errors, reset.
module tb_vc_input_port;
  import noc_params::*;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [DEST_ADDR_SIZE_X-1:0] x_current;
  logic [DEST_ADDR_SIZE_Y-1:0] y_current;
  flit_t                       data_i;
  logic                        valid_flit;
  logic [1:0]                  va_valid;
  logic [1:0][VC_SIZE-1:0]     va_new_vc;
  logic                        sa_valid;
  logic [VC_SIZE-1:0]          sa_sel;
  flit_t                       xb_flit;
  logic                        xb_valid;
  logic [1:0]                  va_req, sa_req, is_full, is_empty;
  port_t [1:0]                 out_port;
  logic                        error;

  int err_cnt = 0;
  int chk_cnt = 0;

  vc_input_port #(.VC_NUM(2), .BUFFER_SIZE(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .x_current    (x_current),
    .y_current    (y_current),
    .data_i       (data_i),
    .valid_flit_i (valid_flit),
    .va_valid_i   (va_valid),
    .va_new_vc_i  (va_new_vc),
    .sa_valid_i   (sa_valid),
    .sa_sel_vc_i  (sa_sel),
    .xb_flit_o    (xb_flit),
    .xb_valid_o   (xb_valid),
    .va_request_o (va_req),
    .sa_request_o (sa_req),
    .out_port_o   (out_port),
    .is_full_o    (is_full),
    .is_empty_o   (is_empty),
    .error_o      (error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, need finish)");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic flit_t mk(flit_label_t l, logic [VC_SIZE-1:0] vc,
                               logic [3:0] xd, logic [3:0] yd, logic [7:0] tag);
    flit_t f;
    f.flit_label = l;
    f.vc_id      = vc;
    f.data       = {tag, yd, xd};
    return f;
  endfunction

  function automatic flit_t retag(flit_t f, logic [VC_SIZE-1:0] v);
    flit_t r;
    r       = f;
    r.vc_id = v;
    return r;
  endfunction

  task automatic send(input flit_t f);
    data_i     = f;
    valid_flit = 1'b1;
    cycle();
    valid_flit = 1'b0;
  endtask

  task automatic va_grant(input int vc, input logic [VC_SIZE-1:0] nv);
    va_valid      = 2'b00;
    va_valid[vc]  = 1'b1;
    va_new_vc[vc] = nv;
    cycle();
    va_valid = 2'b00;
  endtask

  task automatic sa_grant(input logic [VC_SIZE-1:0] vc);
    sa_valid = 1'b1;
    sa_sel   = vc;
    cycle();
    sa_valid = 1'b0;
  endtask

  flit_t pkt [8];
  flit_t ht, extra;
  flit_t a [3];
  flit_t b [2];

  initial begin
    rst = 1'b1; x_current = 4'd2; y_current = 4'd2;
    data_i = '0; valid_flit = 1'b0; va_valid = 2'b00; va_new_vc = '0;
    sa_valid = 1'b0; sa_sel = '0;
    cycle(); cycle();

    // Reset state
    check("rst_empty", is_empty, 2'b11);
    check("rst_full", is_full, 2'b00);
    check("rst_req", {va_req, sa_req}, 4'b0000);
    check("rst_xb", {xb_valid, xb_flit}, '0);
    check("rst_err", error, 1'b0);
    check("rst_port", out_port, '0);
    rst = 1'b0;
    cycle();

    // HEADTAIL on VC1 through VA and SA
    ht = mk(HEADTAIL, 1'b1, 4'd3, 4'd2, 8'h11);
    send(ht);
    check("ht_empty", is_empty, 2'b01);
    check("ht_va_t1", va_req, 2'b00);
    cycle();
    check("ht_va_t2", va_req, 2'b10);
    check("ht_port", out_port[1], EAST);
    va_grant(1, 1'b0);
    check("ht_va_done", va_req, 2'b00);
    check("ht_sa_req", sa_req, 2'b10);
    sa_grant(1'b1);
    check("ht_xb_valid", xb_valid, 1'b1);
    check("ht_xb_flit", xb_flit, retag(ht, 1'b0));
    check("ht_empty2", is_empty, 2'b11);
    check("ht_sa_off", sa_req, 2'b00);
    cycle();
    check("ht_xb_low", xb_valid, 1'b0);
    check("ht_idle", va_req, 2'b00);

    // Fill VC0, overflow, simultaneous write+pop on full
    pkt[0] = mk(HEAD, 1'b0, 4'd1, 4'd2, 8'h20);
    for (int i = 1; i < 7; i++) pkt[i] = mk(BODY, 1'b0, 4'd0, 4'd0, 8'(8'h20 + i));
    pkt[7] = mk(TAIL, 1'b0, 4'd0, 4'd0, 8'h27);
    for (int i = 0; i < 8; i++) send(pkt[i]);
    check("full_flag", is_full, 2'b01);
    check("full_notempty", is_empty, 2'b10);
    check("full_noerr", error, 1'b0);
    extra = mk(BODY, 1'b0, 4'd0, 4'd0, 8'hEE);
    send(extra);
    check("ovf_err", error, 1'b1);
    check("ovf_full", is_full, 2'b01);
    cycle();
    check("ovf_err_pulse", error, 1'b0);
    check("full_va_req", va_req, 2'b01);
    check("full_port", out_port[0], WEST);
    va_grant(0, 1'b1);
    check("full_sa_req", sa_req, 2'b01);
    ht = mk(HEADTAIL, 1'b0, 4'd2, 4'd2, 8'h90);
    data_i = ht; valid_flit = 1'b1; sa_valid = 1'b1; sa_sel = 1'b0;
    cycle();
    valid_flit = 1'b0; sa_valid = 1'b0;
    check("wp_full", is_full, 2'b01);
    check("wp_noerr", error, 1'b0);
    check("wp_xb_valid", xb_valid, 1'b1);
    check("wp_xb0", xb_flit, retag(pkt[0], 1'b1));
    for (int i = 1; i < 8; i++) begin
      sa_grant(1'b0);
      check($sformatf("drain_%0d", i), xb_flit, retag(pkt[i], 1'b1));
    end
    check("tail_no_va_yet", va_req, 2'b00);
    cycle();
    check("next_head_va", va_req, 2'b01);
    va_grant(0, 1'b0);
    sa_grant(1'b0);
    check("next_head_xb", xb_flit, retag(ht, 1'b0));
    check("next_head_empty", is_empty, 2'b11);
    cycle();

    // Interleaved packets on both VCs
    a[0] = mk(HEAD, 1'b0, 4'd2, 4'd3, 8'hA0);
    a[1] = mk(BODY, 1'b0, 4'd0, 4'd0, 8'hA1);
    a[2] = mk(TAIL, 1'b0, 4'd0, 4'd0, 8'hA2);
    b[0] = mk(HEAD, 1'b1, 4'd2, 4'd0, 8'hB0);
    b[1] = mk(TAIL, 1'b1, 4'd0, 4'd0, 8'hB1);
    send(a[0]); send(b[0]); send(a[1]); send(b[1]); send(a[2]);
    check("il_va_req", va_req, 2'b11);
    check("il_port0", out_port[0], SOUTH);
    check("il_port1", out_port[1], NORTH);
    va_valid = 2'b11; va_new_vc[0] = 1'b1; va_new_vc[1] = 1'b0;
    cycle();
    va_valid = 2'b00;
    check("il_sa_req", sa_req, 2'b11);
    sa_grant(1'b0); check("il_a0", xb_flit, retag(a[0], 1'b1));
    sa_grant(1'b1); check("il_b0", xb_flit, retag(b[0], 1'b0));
    sa_grant(1'b0); check("il_a1", xb_flit, retag(a[1], 1'b1));
    sa_grant(1'b1); check("il_b1", xb_flit, retag(b[1], 1'b0));
    sa_grant(1'b0); check("il_a2", xb_flit, retag(a[2], 1'b1));
    check("il_empty", is_empty, 2'b11);
    check("il_idle", {va_req, sa_req}, 4'b0000);

    // BODY into idle VC1, then a grant to a non-active VC
    send(mk(BODY, 1'b1, 4'd0, 4'd0, 8'h55));
    check("body_err_t1", error, 1'b0);
    cycle();
    check("body_err", error, 1'b1);
    check("body_no_va", va_req, 2'b00);
    cycle();
    check("body_err_pulse", error, 1'b0);
    check("body_stays", is_empty, 2'b01);
    sa_grant(1'b1);
    check("bad_sa_err", error, 1'b1);
    check("bad_sa_xb", xb_valid, 1'b0);
    cycle();
    check("bad_sa_pulse", error, 1'b0);

    // Reset while VC0 is ACTIVE with three flits
    send(mk(HEAD, 1'b0, 4'd5, 4'd2, 8'hC0));
    send(mk(BODY, 1'b0, 4'd0, 4'd0, 8'hC1));
    send(mk(BODY, 1'b0, 4'd0, 4'd0, 8'hC2));
    va_grant(0, 1'b1);
    check("pre_rst_active", sa_req, 2'b01);
    check("pre_rst_port", out_port[0], EAST);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("mid_rst_empty", is_empty, 2'b11);
    check("mid_rst_full", is_full, 2'b00);
    check("mid_rst_req", {va_req, sa_req}, 4'b0000);
    check("mid_rst_port", out_port, '0);
    check("mid_rst_xb", {xb_valid, xb_flit}, '0);
    check("mid_rst_err", error, 1'b0);
    ht = mk(HEADTAIL, 1'b0, 4'd3, 4'd2, 8'hA1);
    send(ht);
    cycle();
    check("post_rst_va", va_req, 2'b01);
    check("post_rst_port", out_port[0], EAST);
    va_grant(0, 1'b1);
    sa_grant(1'b0);
    check("post_rst_xb_valid", xb_valid, 1'b1);
    check("post_rst_xb", xb_flit, retag(ht, 1'b1));
    cycle();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
